// File: rtl/mips_bus_interface.sv
// mips_bus_interface: arbitrates core fetch/data requests onto one Avalon master port.
// Define BUS_TIMEOUT_EN to abort accesses stalled for TIMEOUT_CYCLES waitrequest cycles.
module mips_bus_interface #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, FETCH, DATA, ABORT} state_t;
   state_t state, state_n;
   logic xfer, done, timeout, zero_wr;
   assign xfer    = state == FETCH || state == DATA;
   assign done    = xfer && !waitrequest;
   assign zero_wr = d_req && d_we && d_be == 4'b0000;
   assign busy    = state != IDLE;
`ifdef BUS_TIMEOUT_EN
   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
   logic [W-1:0] cnt;
   assign timeout = xfer && waitrequest && cnt == LAST;
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:        state_n = d_req ? (zero_wr ? IDLE : DATA) : i_req ? FETCH : IDLE;
         FETCH, DATA: state_n = done ? IDLE : timeout ? ABORT : state;
         default:     state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         address    <= '0;
         writedata  <= '0;
         byteenable <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
         i_ready    <= 1'b0;
         d_ready    <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
`ifdef BUS_TIMEOUT_EN
         cnt        <= '0;
         err        <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         if (state == IDLE) begin
`ifdef BUS_TIMEOUT_EN
            cnt <= '0;
`endif
            if (d_req) begin
               // an all-lanes-off store completes without touching the bus
               d_ready <= zero_wr;
               if (!zero_wr) begin
                  address    <= d_addr & ~32'h3;
                  byteenable <= d_be;
                  writedata  <= d_wdata;
                  read       <= !d_we;
                  write      <= d_we;
               end
            end else if (i_req) begin
               address    <= i_addr & ~32'h3;
               byteenable <= 4'hf;
               read       <= 1'b1;
               write      <= 1'b0;
            end
         end else if (done) begin
            read    <= 1'b0;
            write   <= 1'b0;
            i_ready <= state == FETCH;
            d_ready <= state == DATA;
            if (state == FETCH) i_rdata <= readdata;
            else if (read) d_rdata <= readdata;
         end
`ifdef BUS_TIMEOUT_EN
         else if (timeout) begin
            read    <= 1'b0;
            write   <= 1'b0;
            err     <= 1'b1;
            i_ready <= state == FETCH;
            d_ready <= state == DATA;
            if (state == FETCH) i_rdata <= '0;
            else d_rdata <= '0;
         end else if (xfer) cnt <= cnt + 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_mips_bus_interface.sv
// tb_mips_bus_interface: scenario tasks with a queue scoreboard of expected read data.
module tb_mips_bus_interface;
`ifdef BUS_TIMEOUT_EN
   localparam int TO = 4;
   localparam int WAITS = 3;
`else
   localparam int TO = 64;
   localparam int WAITS = 5;
`endif
   logic clk = 0, reset = 1;
   logic i_req = 0, d_req = 0, d_we = 0, waitrequest = 0;
   logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, readdata = 0;
   logic [3:0] d_be = 0;
   logic i_ready, d_ready, read, write, busy, err;
   logic [31:0] i_rdata, d_rdata, address, writedata;
   logic [3:0] byteenable;
   int total = 0, bad = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;

   always #5 clk = ~clk;

   mips_bus_interface #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .address(address), .read(read), .write(write), .waitrequest(waitrequest),
      .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
      .busy(busy), .err(err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      tick();
      tick();
      reset = 0;
      total++; if ({read, write, busy, i_ready, d_ready, err} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", {read, write, busy, i_ready, d_ready, err}); end
      total++; if ({address, writedata, byteenable} !== 68'h0) begin bad++; $display("FAIL reset_bus got=%h/%h/%h exp=0", address, writedata, byteenable); end
      total++; if ({i_rdata, d_rdata} !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0", i_rdata, d_rdata); end
   endtask

   task automatic test_fetch;
      i_req = 1; i_addr = 32'hBFC00000; readdata = 32'h12345678; waitrequest = 0;
      exp_q.push_back(32'h12345678);
      tick();
      i_req = 0;
      total++; if ({read, write, busy} !== 3'b101) begin bad++; $display("FAIL fetch_strobe got=%b exp=101", {read, write, busy}); end
      total++; if (address !== 32'hBFC00000 || byteenable !== 4'hf) begin bad++; $display("FAIL fetch_addr got=%h/%h exp=bfc00000/f", address, byteenable); end
      tick();
      e = exp_q.pop_front();
      total++; if (i_ready !== 1'b1 || i_rdata !== e) begin bad++; $display("FAIL fetch_ready got=%b/%h exp=1/%h", i_ready, i_rdata, e); end
      total++; if ({read, busy} !== 2'b00) begin bad++; $display("FAIL fetch_idle got=%b exp=00", {read, busy}); end
      readdata = 32'h0;
      tick();
      total++; if (i_ready !== 1'b0 || i_rdata !== e) begin bad++; $display("FAIL fetch_pulse got=%b/%h exp=0/%h", i_ready, i_rdata, e); end
   endtask

   task automatic test_priority;
      i_req = 1; i_addr = 32'h00000104; readdata = 32'hCAFEF00D;
      d_req = 1; d_we = 1; d_addr = 32'hBFC00402; d_be = 4'b1100; d_wdata = 32'hAABB0000;
      tick();
      d_req = 0;
      total++; if ({read, write} !== 2'b01 || address !== 32'hBFC00400) begin bad++; $display("FAIL prio_write got=%b/%h exp=01/bfc00400", {read, write}, address); end
      total++; if (byteenable !== 4'b1100 || writedata !== 32'hAABB0000) begin bad++; $display("FAIL prio_wdata got=%h/%h exp=c/aabb0000", byteenable, writedata); end
      tick();
      total++; if (d_ready !== 1'b1 || {read, write} !== 2'b00 || d_rdata !== 32'h0) begin bad++; $display("FAIL prio_gap got=%b/%b/%h exp=1/00/0", d_ready, {read, write}, d_rdata); end
      exp_q.push_back(32'hCAFEF00D);
      tick();
      i_req = 0;
      total++; if (read !== 1'b1 || address !== 32'h00000104) begin bad++; $display("FAIL prio_fetch got=%b/%h exp=1/00000104", read, address); end
      tick();
      e = exp_q.pop_front();
      total++; if (i_ready !== 1'b1 || i_rdata !== e) begin bad++; $display("FAIL prio_iready got=%b/%h exp=1/%h", i_ready, i_rdata, e); end
      tick();
   endtask

   task automatic test_wait;
      int stable = 1;
      d_req = 1; d_we = 0; d_addr = 32'h00002004; d_be = 4'hf; waitrequest = 1; readdata = 32'hDEADBEEF;
      exp_q.push_back(32'hDEADBEEF);
      tick();
      d_req = 0;
      for (int i = 0; i < WAITS; i++) begin
         if (read !== 1'b1 || write !== 1'b0 || address !== 32'h00002004 || byteenable !== 4'hf || d_ready !== 1'b0) stable = 0;
         tick();
      end
      total++; if (stable !== 1) begin bad++; $display("FAIL wait_stable got=%0d exp=1", stable); end
      waitrequest = 0;
      total++; if (read !== 1'b1) begin bad++; $display("FAIL wait_last got=%b exp=1", read); end
      tick();
      e = exp_q.pop_front();
      total++; if (d_ready !== 1'b1 || d_rdata !== e) begin bad++; $display("FAIL wait_latency got=%b/%h exp=1/%h", d_ready, d_rdata, e); end
      tick();
   endtask

   task automatic test_reset_mid;
      int seen = 0;
      d_req = 1; d_we = 0; d_addr = 32'h00003000; d_be = 4'hf; waitrequest = 1; readdata = 32'h55AA55AA;
      tick();
      d_req = 0;
      tick();
      reset = 1; waitrequest = 0;
      tick();
      reset = 0;
      total++; if ({read, busy, d_ready} !== 3'b000) begin bad++; $display("FAIL rstmid_state got=%b exp=000", {read, busy, d_ready}); end
      total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", d_rdata); end
      for (int i = 0; i < 5; i++) begin
         if (d_ready !== 1'b0 || read !== 1'b0) seen++;
         tick();
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_noready got=%0d exp=0", seen); end
   endtask

   task automatic test_be_zero;
      d_req = 1; d_we = 1; d_addr = 32'h00004000; d_be = 4'b0000; d_wdata = 32'h11111111;
      tick();
      d_req = 0;
      total++; if ({d_ready, write, read, busy} !== 4'b1000) begin bad++; $display("FAIL bezero_ready got=%b exp=1000", {d_ready, write, read, busy}); end
      tick();
      total++; if ({d_ready, write} !== 2'b00) begin bad++; $display("FAIL bezero_pulse got=%b exp=00", {d_ready, write}); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a;
      bit ok;
      waitrequest = 0;
      for (int n = 0; n < 4; n++) begin
         a = $urandom;
         readdata = $urandom;
         exp_q.push_back(readdata);
         d_req = 1; d_we = 0; d_addr = a; d_be = 4'hf;
         ok = 0;
         for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (read && write) begin total++; bad++; $display("FAIL b2b_both got=11 exp=not11"); end
            if (read && address !== (a & ~32'h3)) begin total++; bad++; $display("FAIL b2b_addr got=%h exp=%h", address, a & ~32'h3); end
            ok = d_ready;
         end
         d_req = 0;
         e = exp_q.pop_front();
         total++; if (!ok || d_rdata !== e) begin bad++; $display("FAIL b2b_data got=%b/%h exp=1/%h", ok, d_rdata, e); end
         total++; if ({read, write, busy} !== 3'b000) begin bad++; $display("FAIL b2b_idle got=%b exp=000", {read, write, busy}); end
      end
      tick();
   endtask

`ifdef BUS_TIMEOUT_EN
   task automatic test_timeout;
      int stable = 1;
      i_req = 1; i_addr = 32'h00000040; waitrequest = 1; readdata = 32'h77777777;
      tick();
      i_req = 0;
      for (int i = 0; i < TO; i++) begin
         if (read !== 1'b1 || err !== 1'b0 || i_ready !== 1'b0) stable = 0;
         tick();
      end
      total++; if (stable !== 1) begin bad++; $display("FAIL to_wait got=%0d exp=1", stable); end
      total++; if ({read, err, i_ready, busy} !== 4'b0111 || i_rdata !== 32'h0) begin bad++; $display("FAIL to_abort got=%b/%h exp=0111/0", {read, err, i_ready, busy}, i_rdata); end
      tick();
      total++; if ({busy, err, i_ready} !== 3'b010) begin bad++; $display("FAIL to_idle got=%b exp=010", {busy, err, i_ready}); end
      waitrequest = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_wait();
      test_reset_mid();
      test_be_zero();
      test_back_to_back();
`ifdef BUS_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mips_bus_interface.md
MIPS_BUS_INTERFACE -- requirements
Module: mips_bus_interface

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64: the number of consecutive waitrequest-high cycles after which an access is aborted (used only under REQ-030).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports i_req in 1, i_addr in 32: instruction-fetch request and byte address from the core.
REQ-005 The block SHALL have ports i_ready out 1, i_rdata out 32: one-cycle fetch-complete pulse and the fetched word.
REQ-006 The block SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_be in 4, d_wdata in 32: data request, write flag, address, byte lanes and store data.
REQ-007 The block SHALL have ports d_ready out 1, d_rdata out 32: one-cycle data-complete pulse and the loaded word.
REQ-008 The block SHALL have Avalon master ports address out 32, read out 1, write out 1, waitrequest in 1, writedata out 32, byteenable out 4, readdata in 32.
REQ-009 The block SHALL have ports busy out 1 (state != IDLE) and err out 1 (sticky timeout flag).

Function
REQ-010 The FSM SHALL have the states IDLE, FETCH, DATA and ABORT.
REQ-011 In IDLE, if d_req is set at the edge, the FSM SHALL go to DATA; otherwise if i_req is set, it SHALL go to FETCH; otherwise it SHALL stay in IDLE. Data has priority over fetch.
REQ-012 On entry to FETCH or DATA, the block SHALL register address, byteenable, writedata and read/write in the same edge, so the bus is driven in the first cycle after the request is sampled.
REQ-013 Bus address SHALL be {req_addr[31:2],2'b00}. Fetch SHALL use byteenable 4'b1111. Data SHALL use byteenable = d_be.
REQ-014 read SHALL be 1 in FETCH, and in DATA when d_we=0. write SHALL be 1 in DATA when d_we=1. read and write SHALL never both be 1.
REQ-015 address, byteenable, writedata, read and write SHALL stay stable while waitrequest=1.
REQ-016 A transfer SHALL complete at the edge where (read|write)=1 and waitrequest=0. On a read, readdata SHALL be captured at that edge.
REQ-017 On completion, the FSM SHALL return to IDLE, drop read/write, and pulse i_ready or d_ready for exactly one cycle with i_rdata/d_rdata valid. Minimum latency: request sampled at edge N gives ready high in cycle N+2.
REQ-018 i_rdata/d_rdata SHALL hold their last value until the next completion of the same port. After a write, d_rdata SHALL be unchanged.
REQ-019 In the cycle after a completion, the block SHALL be in IDLE with read=write=0. Back-to-back transfers SHALL therefore be separated by at least one idle bus cycle.
REQ-020 A data write with d_be=4'b0000 SHALL issue no bus cycle and SHALL pulse d_ready in the next cycle.
REQ-021 If a request is withdrawn mid-transfer, the transfer SHALL still complete and the ready pulse SHALL still be issued.
REQ-022 Requests sampled while not in IDLE SHALL be ignored until IDLE. The core holds req until ready.

Reset
REQ-023 On reset=1 at an edge, the block SHALL go to IDLE, abandoning any transfer. The outputs read, write, i_ready, d_ready and err SHALL be 0, and address, writedata, byteenable, i_rdata, d_rdata and the timeout counter SHALL be cleared to 0.
REQ-024 Reset SHALL override all other events in the same cycle, including a completing transfer: no ready pulse is issued.

Configuration
REQ-030 With BUS_TIMEOUT_EN defined, a counter SHALL count cycles spent in FETCH or DATA with waitrequest=1, cleared on entry to those states. When the count reaches TIMEOUT_CYCLES, the FSM SHALL enter ABORT: read and write drop, err sets, and the matching ready pulses with rdata=32'h0. ABORT SHALL then return to IDLE in the next cycle.
REQ-031 Without BUS_TIMEOUT_EN, the block SHALL have no counter, SHALL never enter ABORT, SHALL tie err to 0, and SHALL wait indefinitely.

Verification
REQ-040 Fetch with i_addr=32'hBFC00000 and waitrequest=0 SHALL give read=1 and address=BFC00000 next cycle, then i_ready pulse with i_rdata equal to readdata at cycle +2.
REQ-041 i_req and d_req in the same cycle, with d_we=1, d_addr=BFC00402, d_be=4'b1100, d_wdata=32'hAABB0000: write occurs first at address BFC00400, then the fetch runs after one idle cycle.
REQ-042 Load with waitrequest held high for 5 cycles: address and read SHALL stay stable all 5 cycles, and d_ready SHALL be seen 7 cycles after the request is sampled.
REQ-043 Reset asserted while waitrequest=1 mid-read: next cycle read=0, busy=0, and no d_ready is ever issued.
REQ-044 Write with d_be=0: no write strobe seen on the bus, and d_ready pulses in the next cycle.
REQ-045 With BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, waitrequest stuck at 1: after 4 wait cycles read drops, err=1 is held, and i_ready pulses with i_rdata=0.
